// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_if
//  Description : Load/store request channel and valid/ready response channel
//                between the core datapath (master) and a memory responder
//                (slave).
//  Signals     : req_valid / req_ready   request handshake
//                req_wen                 1 = store, 0 = load
//                req_addr [31:0]         byte address
//                req_wdata[31:0]         lane-aligned store data
//                req_wmask[7:0]          byte enables, bits [3:0] used
//                resp_valid / resp_ready response handshake
//                resp_rdata[31:0]        load data (0 for stores and errors)
//                resp_err                address outside the array
//  Revision    : 1.0  initial release
// ============================================================================
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Memory-side responder for the core load/store port. Holds a
//                word-organised local array, accepts one request at a time
//                and answers it LATENCY cycles after acceptance on a
//                valid/ready response channel.
//  Ports       : clk   clock, all state changes on the rising edge
//                rst   asynchronous active-low reset
//                bus   data_mem_if.slave request/response channel
//  Parameters  : BASE_ADDR   byte address of word 0
//                DEPTH_WORDS number of 32-bit words, power of two, >= 2
//                LATENCY     acceptance-to-resp_valid cycles, 1..15
//  Revision    : 1.0  initial release
// ============================================================================
module data_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic       clk,
  input  logic       rst,
  data_mem_if.slave  bus
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(4 * DEPTH_WORDS);
  // BASE_ADDR + SPAN is assumed not to overflow 32 bits; addresses below
  // BASE_ADDR are simply out of range, there is no wrap-around.
  localparam logic [31:0] LIMIT    = BASE_ADDR + SPAN;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // With a single-cycle latency the response is already due on the cycle
  // after acceptance, so the wait state is skipped entirely.
  localparam state_t ACCEPT_NEXT = (LATENCY == 1) ? RESP : WAIT;

  state_t      state;
  logic [3:0]  cnt;
  logic        resp_valid_reg;
  logic [31:0] resp_rdata_reg;
  logic        resp_err_reg;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]      offset;
  logic [IDX_W-1:0] word_idx;
  logic             in_range;
  logic             accept;
  logic [31:0]      rd_word;
  logic             unused_bits;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  assign offset   = bus.req_addr - BASE_ADDR;
  assign word_idx = offset[IDX_W+1:2];
  assign in_range = (bus.req_addr >= BASE_ADDR) && (bus.req_addr < LIMIT);

  // Acceptance depends on state only, so a request presented during RESP is
  // never taken on the response handshake edge.
  assign accept   = bus.req_valid && (state == IDLE);
  assign rd_word  = mem[word_idx];

  // Offset bits above the array, the byte-offset bits and the upper mask
  // nibble do not select anything.
  assign unused_bits = ^{offset[31:IDX_W+2], offset[1:0], bus.req_wmask[7:4]};

  // --------------------------------------------------------------------------
  // Storage: byte-masked write at the acceptance edge. Not reset, so a store
  // accepted before a reset stays committed.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept && in_range && bus.req_wen) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.req_wmask[b]) begin
          mem[word_idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered response outputs. The response word is
  // captured at acceptance, so later changes on req_* have no effect.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= 32'd0;
      resp_err_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            resp_rdata_reg <= (in_range && !bus.req_wen) ? rd_word : 32'd0;
            resp_err_reg   <= !in_range;
            state          <= ACCEPT_NEXT;
            if (ACCEPT_NEXT == RESP) begin
              resp_valid_reg <= 1'b1;
              cnt            <= 4'd0;
            end else begin
              cnt            <= CNT_INIT;
            end
          end
        end

        WAIT: begin
          // cnt holds the number of edges still to go before RESP.
          if (cnt == 4'd1) begin
            state          <= RESP;
            resp_valid_reg <= 1'b1;
            cnt            <= 4'd0;
          end else begin
            cnt            <= cnt - 4'd1;
          end
        end

        RESP: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= 32'd0;
            resp_err_reg   <= 1'b0;
          end
        end

        default: begin
          state          <= IDLE;
          cnt            <= 4'd0;
          resp_valid_reg <= 1'b0;
          resp_rdata_reg <= 32'd0;
          resp_err_reg   <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_rdata = resp_rdata_reg;
  assign bus.resp_err   = resp_err_reg;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Directed self-checking bench for data_mem_responder with
//                default parameters (BASE 0x80000000, 1024 words, LATENCY 2).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_data_mem_responder;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  data_mem_if bus ();

  data_mem_responder #(
    .BASE_ADDR  (32'h8000_0000),
    .DEPTH_WORDS(1024),
    .LATENCY    (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got hang, required completion");
    $fatal(1, "watchdog");
  end

  // Issue one request, wait (bounded) for the response, then complete the
  // handshake. lat counts cycles from the acceptance edge; 99 = timeout.
  task automatic send_req(input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [7:0] wmask,
                          output logic [31:0] rdata, output logic err,
                          output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus.req_valid = 1'b1;
    bus.req_wen   = wen;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wmask = wmask;
    @(posedge clk);
    #1;
    // Scramble request fields after acceptance; they must be ignored.
    bus.req_valid = 1'b0;
    bus.req_wen   = ~wen;
    bus.req_addr  = 32'h8000_0000;
    bus.req_wdata = 32'hFFFF_FFFF;
    bus.req_wmask = 8'hFF;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.resp_valid) lat = 99;
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
    tests++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got %b want 0", bus.resp_valid); end
    tests++; if (bus.resp_rdata !== 32'd0) begin fails++; $display("FAIL reset_resp_rdata got %h want 0", bus.resp_rdata); end
    tests++; if (bus.resp_err !== 1'b0) begin fails++; $display("FAIL reset_resp_err got %b want 0", bus.resp_err); end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat;
    send_req(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, rd, er, lat);
    tests++; if (lat !== 2) begin fails++; $display("FAIL store_latency got %0d want 2", lat); end
    tests++; if (rd !== 32'd0) begin fails++; $display("FAIL store_rdata got %h want 0", rd); end
    tests++; if (er !== 1'b0) begin fails++; $display("FAIL store_err got %b want 0", er); end
    tests++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL post_handshake_valid got %b want 0", bus.resp_valid); end
    tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL post_handshake_ready got %b want 1", bus.req_ready); end
    send_req(1'b0, 32'h8000_0010, 32'h0, 8'h00, rd, er, lat);
    tests++; if (lat !== 2) begin fails++; $display("FAIL load_latency got %0d want 2", lat); end
    tests++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL load_word got %h want deadbeef", rd); end
    tests++; if (er !== 1'b0) begin fails++; $display("FAIL load_err got %b want 0", er); end
    // Low address bits are ignored for indexing.
    send_req(1'b0, 32'h8000_0013, 32'h0, 8'h00, rd, er, lat);
    tests++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL load_unaligned got %h want deadbeef", rd); end
  endtask

  task automatic test_masks();
    logic [31:0] rd; logic er; int lat;
    send_req(1'b1, 32'h8000_0010, 32'h00AA_0000, 8'h04, rd, er, lat);
    send_req(1'b0, 32'h8000_0010, 32'h0, 8'h00, rd, er, lat);
    tests++; if (rd !== 32'hDEAA_BEEF) begin fails++; $display("FAIL mask_byte2 got %h want deaabeef", rd); end
    send_req(1'b1, 32'h8000_0010, 32'h0000_1234, 8'h03, rd, er, lat);
    send_req(1'b0, 32'h8000_0010, 32'h0, 8'h00, rd, er, lat);
    tests++; if (rd !== 32'hDEAA_1234) begin fails++; $display("FAIL mask_half0 got %h want deaa1234", rd); end
    send_req(1'b1, 32'h8000_0010, 32'h5555_5555, 8'hF0, rd, er, lat);
    tests++; if (lat !== 2 || er !== 1'b0) begin fails++; $display("FAIL mask_upper_resp got lat=%0d err=%b want lat=2 err=0", lat, er); end
    send_req(1'b1, 32'h8000_0010, 32'h6666_6666, 8'h00, rd, er, lat);
    tests++; if (lat !== 2 || rd !== 32'd0) begin fails++; $display("FAIL mask_zero_resp got lat=%0d rdata=%h want lat=2 rdata=0", lat, rd); end
    send_req(1'b0, 32'h8000_0010, 32'h0, 8'h00, rd, er, lat);
    tests++; if (rd !== 32'hDEAA_1234) begin fails++; $display("FAIL mask_none_unchanged got %h want deaa1234", rd); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic er; int lat;
    send_req(1'b1, 32'h8000_0000, 32'h0102_0304, 8'h0F, rd, er, lat);
    send_req(1'b1, 32'h8000_0FFC, 32'hA5A5_5A5A, 8'h0F, rd, er, lat);
    tests++; if (er !== 1'b0) begin fails++; $display("FAIL last_word_err got %b want 0", er); end
    send_req(1'b0, 32'h7FFF_FFFC, 32'h0, 8'h00, rd, er, lat);
    tests++; if (er !== 1'b1 || rd !== 32'd0) begin fails++; $display("FAIL oor_low got err=%b rdata=%h want err=1 rdata=0", er, rd); end
    tests++; if (lat !== 2) begin fails++; $display("FAIL oor_low_latency got %0d want 2", lat); end
    send_req(1'b1, 32'h8000_1000, 32'h1111_1111, 8'h0F, rd, er, lat);
    tests++; if (er !== 1'b1 || rd !== 32'd0) begin fails++; $display("FAIL oor_high got err=%b rdata=%h want err=1 rdata=0", er, rd); end
    send_req(1'b0, 32'h8000_0000, 32'h0, 8'h00, rd, er, lat);
    tests++; if (rd !== 32'h0102_0304 || er !== 1'b0) begin fails++; $display("FAIL oor_no_write got %h err=%b want 01020304 err=0", rd, er); end
    send_req(1'b0, 32'h8000_0FFC, 32'h0, 8'h00, rd, er, lat);
    tests++; if (rd !== 32'hA5A5_5A5A || er !== 1'b0) begin fails++; $display("FAIL last_word_load got %h err=%b want a5a55a5a err=0", rd, er); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; int n;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wen = 1'b0;
    bus.req_addr = 32'h8000_0010; bus.req_wdata = 32'h0; bus.req_wmask = 8'h00;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    tests++; if (bus.resp_valid !== 1'b1) begin fails++; $display("FAIL bp_resp_timeout got %b want 1", bus.resp_valid); end
    // New request presented while the response is stalled.
    bus.req_valid = 1'b1; bus.req_wen = 1'b1;
    bus.req_addr = 32'h8000_0014; bus.req_wdata = 32'h5678_ABCD; bus.req_wmask = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      tests++; if (bus.resp_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d] got %b want 1", i, bus.resp_valid); end
      tests++; if (bus.resp_rdata !== 32'hDEAA_1234) begin fails++; $display("FAIL bp_rdata[%0d] got %h want deaa1234", i, bus.resp_rdata); end
      tests++; if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL bp_req_ready[%0d] got %b want 0", i, bus.req_ready); end
      @(posedge clk);
      #1;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    tests++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin fails++; $display("FAIL bp_handshake got ready=%b valid=%b want ready=1 valid=0", bus.req_ready, bus.resp_valid); end
    tests++; if (bus.resp_rdata !== 32'd0) begin fails++; $display("FAIL bp_rdata_cleared got %h want 0", bus.resp_rdata); end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    tests++; if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL bp_accept_next got ready=%b want 0", bus.req_ready); end
    n = 0;
    while (!bus.resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    tests++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0) begin fails++; $display("FAIL bp_store_resp got valid=%b err=%b want valid=1 err=0", bus.resp_valid, bus.resp_err); end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    send_req(1'b0, 32'h8000_0014, 32'h0, 8'h00, rd, er, lat);
    tests++; if (rd !== 32'h5678_ABCD) begin fails++; $display("FAIL bp_store_data got %h want 5678abcd", rd); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic er; int lat; logic seen;
    // Store, then reset one cycle after acceptance: write must persist.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wen = 1'b1;
    bus.req_addr = 32'h8000_0020; bus.req_wdata = 32'hCAFE_F00D; bus.req_wmask = 8'h0F;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; seen |= bus.resp_valid; end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; seen |= bus.resp_valid; end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL rst_store_valid got %b want 0", seen); end
    tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL rst_store_ready got %b want 1", bus.req_ready); end
    // Load, then reset one cycle after acceptance.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wen = 1'b0; bus.req_addr = 32'h8000_0020;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst = 1'b0;
    seen = 1'b0;
    repeat (3) begin @(posedge clk); #1; seen |= bus.resp_valid; end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; seen |= bus.resp_valid; end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL rst_load_valid got %b want 0", seen); end
    tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL rst_load_ready got %b want 1", bus.req_ready); end
    send_req(1'b0, 32'h8000_0020, 32'h0, 8'h00, rd, er, lat);
    tests++; if (rd !== 32'hCAFE_F00D) begin fails++; $display("FAIL rst_store_committed got %h want cafef00d", rd); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_wen    = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_wmask  = 8'h0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_store_load();
    test_masks();
    test_out_of_range();
    test_backpressure();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
